// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit drives the request and address; memory returns the data word and the ack strobe.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC owner and instruction fetcher for the single-cycle RISC-V core.
// Each instruction goes REQ -> EXEC; misaligned targets and ack timeouts end in a sticky HALT.
module instr_fetch_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              ACK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  instr_fetch_unit_if.master        imem,
  input  logic                      pc_src,
  input  logic [XLEN-1:0]           target_addr,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [XLEN-1:0]           pc,
  output logic [XLEN-1:0]           pc_plus4,
  output logic [6:0]                opcode,
  output logic [2:0]                funct3,
  output logic                      funct7_5,
  output logic [4:0]                rs1,
  output logic [4:0]                rs2,
  output logic [4:0]                rd,
  output logic                      halted,
  output logic [1:0]                fault_code
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    EXEC = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [31:0]     instr_r;
  logic [CW-1:0]   cnt_r;
  logic [1:0]      fault_r;
  logic            req_r;
  logic            valid_r;
  logic            halted_r;

  // Fetch/execute/halt sequencer; the status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= REQ;
      pc_r     <= RESET_PC;
      instr_r  <= NOP;
      cnt_r    <= '0;
      fault_r  <= 2'b00;
      req_r    <= 1'b1;
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        REQ: begin
          if (imem.imem_ack) begin
            instr_r <= imem.imem_rdata;
            cnt_r   <= '0;
            state_r <= EXEC;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            state_r  <= HALT;
            fault_r  <= 2'b10;
            req_r    <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        EXEC: begin
          valid_r <= 1'b0;
          if (!pc_src) begin
            pc_r    <= pc_r + XLEN'(4);
            state_r <= REQ;
            req_r   <= 1'b1;
          end else if (target_addr[1:0] == 2'b00) begin
            pc_r    <= target_addr;
            state_r <= REQ;
            req_r   <= 1'b1;
          end else begin
            // pc keeps the address of the jump/branch that produced the bad target
            state_r  <= HALT;
            fault_r  <= 2'b01;
            halted_r <= 1'b1;
          end
        end
        HALT: begin
          state_r  <= HALT;
          req_r    <= 1'b0;
          valid_r  <= 1'b0;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= HALT;
          req_r    <= 1'b0;
          valid_r  <= 1'b0;
          halted_r <= 1'b1;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;

  assign instr_valid = valid_r;
  assign instr       = instr_r;
  assign pc          = pc_r;
  assign pc_plus4    = pc_r + XLEN'(4);
  assign halted      = halted_r;
  assign fault_code  = fault_r;

  assign opcode   = instr_r[6:0];
  assign funct3   = instr_r[14:12];
  assign funct7_5 = instr_r[30];
  assign rs1      = instr_r[19:15];
  assign rs2      = instr_r[24:20];
  assign rd       = instr_r[11:7];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal checks,
// then randomized memory latency / control flow against a behavioural model.
module tb_instr_fetch_unit;
  localparam int          ACK_TIMEOUT = 16;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src;
  logic [31:0] target;
  logic        instr_valid, funct7_5, halted;
  logic [31:0] instr, pc, pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [1:0]  fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .reset(rst), .imem(bus.master),
    .pc_src(pc_src), .target_addr(target),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1(rs1), .rs2(rs2), .rd(rd), .halted(halted), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Behavioural model: what has been fetched, where we are, and whether we stopped.
  bit          m_known = 1'b0;
  bit          m_exec, m_halted;
  int          m_wait;
  logic [31:0] m_pc, m_instr;
  logic [1:0]  m_fault;

  task automatic model_update();
    if (rst) begin
      m_known = 1'b1; m_pc = RESET_PC; m_instr = NOP;
      m_exec = 1'b0; m_halted = 1'b0; m_fault = 2'd0; m_wait = 0;
    end else if (!m_known || m_halted) begin
      m_wait = m_wait;
    end else if (m_exec) begin
      m_exec = 1'b0;
      if (!pc_src) m_pc = m_pc + 32'd4;
      else if (target % 4 != 0) begin m_halted = 1'b1; m_fault = 2'd1; end
      else m_pc = target;
    end else if (bus.imem_ack) begin
      m_instr = bus.imem_rdata; m_exec = 1'b1; m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait == ACK_TIMEOUT) begin m_halted = 1'b1; m_fault = 2'd2; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    if (m_known) begin
      chk("imem_req",    32'(bus.imem_req), 32'(!m_halted && !m_exec));
      chk("imem_addr",   bus.imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_exec));
      chk("halted",      32'(halted), 32'(m_halted));
      chk("fault_code",  32'(fault_code), 32'(m_fault));
      chk("pc",          pc, m_pc);
      chk("pc_plus4",    pc_plus4, m_pc + 32'd4);
      chk("instr",       instr, m_instr);
      chk("opcode",      32'(opcode), 32'(m_instr[6:0]));
      chk("funct3",      32'(funct3), 32'(m_instr[14:12]));
      chk("funct7_5",    32'(funct7_5), 32'(m_instr[30]));
      chk("rs1",         32'(rs1), 32'(m_instr[19:15]));
      chk("rs2",         32'(rs2), 32'(m_instr[24:20]));
      chk("rd",          32'(rd), 32'(m_instr[11:7]));
    end
  endtask

  task automatic step(input logic r, input logic a, input logic [31:0] d,
                      input logic s, input logic [31:0] t);
    rst = r; bus.imem_ack = a; bus.imem_rdata = d; pc_src = s; target = t;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    int ack_pct;
    int halt_cycles;
    rst = 1'b1; bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; pc_src = 1'b0; target = 32'd0;
    @(negedge clk);

    // reset state and zero-latency ADDIs
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd1);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_fault", 32'(fault_code), 32'd0);
    step(1'b0, 1'b1, 32'h0010_0093, 1'b0, 32'd0);
    chk("addi0_valid", 32'(instr_valid), 32'd1);
    chk("addi0_opcode", 32'(opcode), 32'h13);
    chk("addi0_rd", 32'(rd), 32'd1);
    chk("addi0_pc", pc, 32'h0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("addi1_addr", bus.imem_addr, 32'h4);
    step(1'b0, 1'b1, 32'h0020_8113, 1'b0, 32'd0);
    chk("addi1_pc", pc, 32'h4);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0463, 1'b0, 32'd0);
    chk("beq_pc", pc, 32'h8);
    chk("beq_pc4", pc_plus4, 32'hC);
    chk("beq_opcode", 32'(opcode), 32'h63);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h40);
    chk("beq_target", bus.imem_addr, 32'h40);
    // ack delayed 3 cycles: address and old instr hold
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'hBAD0_0000, 1'b1, 32'h3);
    chk("wait_req", 32'(bus.imem_req), 32'd1);
    chk("wait_addr", bus.imem_addr, 32'h40);
    chk("wait_instr", instr, 32'h0000_0463);
    step(1'b0, 1'b1, 32'h0000_006F, 1'b0, 32'd0);
    chk("jal_valid", 32'(instr_valid), 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    step(1'b0, 1'b1, 32'h0000_006F, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h22);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_fault", 32'(fault_code), 32'd1);
    chk("mis_pc", pc, 32'hFFFF_FFFC);
    chk("mis_req", 32'(bus.imem_req), 32'd0);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0);
    chk("halt_instr", instr, 32'h0000_006F);
    chk("halt_fault", 32'(fault_code), 32'd1);

    // timeout: 15 silent cycles are fine, the 16th faults
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("to15_halted", 32'(halted), 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("to16_halted", 32'(halted), 32'd1);
    chk("to16_fault", 32'(fault_code), 32'd2);
    step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'd0);
    chk("ack16_valid", 32'(instr_valid), 32'd1);
    chk("ack16_fault", 32'(fault_code), 32'd0);

    // reset mid-wait with an ack arriving under reset
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h80);
    chk("mid_instr", instr, 32'h0000_0013);
    chk("mid_pc", pc, 32'h0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("mid_req", 32'(bus.imem_req), 32'd1);
    chk("mid_addr", bus.imem_addr, 32'h0);

    // randomized traffic against the model
    ack_pct = 60;
    halt_cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      logic r;
      logic [31:0] t;
      r = (halt_cycles > 3) || ($urandom_range(0, 299) == 0);
      if (r) begin
        case ($urandom_range(0, 4))
          0: ack_pct = 100;
          1: ack_pct = 60;
          2: ack_pct = 25;
          3: ack_pct = 8;
          default: ack_pct = 0;
        endcase
        halt_cycles = 0;
      end
      t = $urandom();
      if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
      step(r, 1'($urandom_range(0, 99) < ack_pct), $urandom(), 1'($urandom_range(0, 1)), t);
      if (m_halted) halt_cycles++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
